// File: rtl/dbn_pkg.sv
// Shared state encoding and datapath width constants for the DBN layer sequencer.
package dbn_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      DRAIN = 3'd2,
      WB    = 3'd3,
      FIN   = 3'd4
   } state_t;

   localparam int SUM_W   = 512;
   localparam int LANE_W  = 32;
   localparam int DATA_W  = 256;
   localparam int NEURONS = 16;

endpackage

// File: rtl/dbn_idx_cnt.sv
// Modulo-MOD index counter with synchronous clear and a terminal-count flag.
module dbn_idx_cnt
   import dbn_pkg::*;
#(
   parameter int MOD = 2,
   parameter int W   = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         tc
);

   assign tc = (cnt == W'(MOD - 1));

   // Wraps to zero after MOD-1, so codes above MOD-1 are never produced.
   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (inc)
         cnt <= tc ? '0 : cnt + W'(1);
   end

endmodule

// File: rtl/dbn_layer_seq.sv
// Sequencer for one DBN layer pass: chunk walk, partial-sum clear/enable,
// per-batch result writeback and a completion pulse.
module dbn_layer_seq
   import dbn_pkg::*;
#(
   parameter int NUM_CHUNK = 49,
   parameter int NUM_BATCH = 2,
   parameter int CHUNK_AW  = 6,
   parameter int BATCH_W   = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                rd_en,
   output logic [CHUNK_AW-1:0] data_addr,
   output logic [CHUNK_AW-1:0] wgt_grp,
   output logic [BATCH_W-1:0]  wgt_bank,
   output logic                acc_clr,
   output logic                acc_en,
   output logic                res_we,
   output logic [BATCH_W-1:0]  res_addr,
   output state_t              fsm_state
);

   state_t              state;
   logic [CHUNK_AW-1:0] chunk;
   logic [BATCH_W-1:0]  batch;
   logic                chunk_tc;
   logic                batch_tc;

   dbn_idx_cnt #(.MOD(NUM_CHUNK), .W(CHUNK_AW)) u_chunk_cnt (
      .clk (clk),
      .rst (rst),
      .inc (state == RUN),
      .clr (state == IDLE),
      .cnt (chunk),
      .tc  (chunk_tc)
   );

   dbn_idx_cnt #(.MOD(NUM_BATCH), .W(BATCH_W)) u_batch_cnt (
      .clk (clk),
      .rst (rst),
      .inc (state == WB),
      .clr (state == IDLE),
      .cnt (batch),
      .tc  (batch_tc)
   );

   // The weight memory is addressed by the same group index as the data memory.
   assign wgt_grp   = data_addr;
   assign fsm_state = state;

   // Outputs are registered: each branch loads the values for the cycle it enters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_en     <= 1'b0;
         data_addr <= '0;
         wgt_bank  <= '0;
         acc_clr   <= 1'b0;
         acc_en    <= 1'b0;
         res_we    <= 1'b0;
         res_addr  <= '0;
      end else begin
         done     <= 1'b0;
         rd_en    <= 1'b0;
         acc_clr  <= 1'b0;
         acc_en   <= 1'b0;
         res_we   <= 1'b0;
         res_addr <= '0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= RUN;
                  busy      <= 1'b1;
                  rd_en     <= 1'b1;
                  data_addr <= '0;
                  wgt_bank  <= '0;
                  acc_clr   <= 1'b1;
               end
            end
            RUN: begin
               // Next cycle consumes the read issued in this one.
               acc_en <= 1'b1;
               if (chunk_tc) begin
                  state <= DRAIN;
               end else begin
                  rd_en     <= 1'b1;
                  data_addr <= chunk + CHUNK_AW'(1);
               end
            end
            DRAIN: begin
               state    <= WB;
               res_we   <= 1'b1;
               res_addr <= batch;
            end
            WB: begin
               if (batch_tc) begin
                  state    <= FIN;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  wgt_bank <= '0;
               end else begin
                  state     <= RUN;
                  rd_en     <= 1'b1;
                  data_addr <= '0;
                  acc_clr   <= 1'b1;
                  wgt_bank  <= batch + BATCH_W'(1);
               end
            end
            FIN: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dbn_layer_seq.sv
// Scoreboard bench for dbn_layer_seq: default 49x2 instance plus a 1x1 boundary instance.
module tb_dbn_layer_seq;
   import dbn_pkg::*;

   localparam int NC = 49;
   localparam int NB = 2;
   localparam int W  = 43;
   localparam logic [1:0] K_WR   = 2'd1;
   localparam logic [1:0] K_DONE = 2'd2;
   // Hand-computed: sum over c=0..48 of (c+1)*((b+1)*3 + c%5)
   localparam logic [31:0] REF_SUM0 = 32'd6125;
   localparam logic [31:0] REF_SUM1 = 32'd9800;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_a = 1'b0;
   logic start_b = 1'b0;
   always #5 clk = ~clk;

   // default instance
   logic       a_busy, a_done, a_rd_en, a_acc_clr, a_acc_en, a_res_we;
   logic [5:0] a_data_addr, a_wgt_grp;
   logic [0:0] a_wgt_bank, a_res_addr;
   state_t     a_state;

   dbn_layer_seq #(.NUM_CHUNK(NC), .NUM_BATCH(NB), .CHUNK_AW(6), .BATCH_W(1)) u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .busy(a_busy), .done(a_done),
      .rd_en(a_rd_en), .data_addr(a_data_addr), .wgt_grp(a_wgt_grp),
      .wgt_bank(a_wgt_bank), .acc_clr(a_acc_clr), .acc_en(a_acc_en),
      .res_we(a_res_we), .res_addr(a_res_addr), .fsm_state(a_state)
   );

   // boundary instance: one chunk, one batch
   logic       b_busy, b_done, b_rd_en, b_acc_clr, b_acc_en, b_res_we;
   logic [0:0] b_data_addr, b_wgt_grp, b_wgt_bank, b_res_addr;
   state_t     b_state;

   dbn_layer_seq #(.NUM_CHUNK(1), .NUM_BATCH(1), .CHUNK_AW(1), .BATCH_W(1)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .busy(b_busy), .done(b_done),
      .rd_en(b_rd_en), .data_addr(b_data_addr), .wgt_grp(b_wgt_grp),
      .wgt_bank(b_wgt_bank), .acc_clr(b_acc_clr), .acc_en(b_acc_en),
      .res_we(b_res_we), .res_addr(b_res_addr), .fsm_state(b_state)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] dval(input int c);
      return 32'(c + 1);
   endfunction

   function automatic logic [31:0] wval(input int b, input int c);
      return 32'((b + 1) * 3 + (c % 5));
   endfunction

   // datapath model: 1-cycle read latency memories feeding one accumulator lane
   logic [31:0] rd_d = '0, rd_w = '0, acc = '0;
   always @(posedge clk) begin
      if (a_rd_en) begin
         rd_d <= dval(int'(a_data_addr));
         rd_w <= wval(int'(a_wgt_bank), int'(a_wgt_grp));
      end
      if (a_acc_clr)
         acc <= '0;
      else if (a_acc_en)
         acc <= acc + rd_d * rd_w;
   end

   // scoreboard
   logic [W-1:0] exp_q[$];
   logic [7:0]   exp_b_q[$];
   int ncyc = 0;
   int base = 0;
   int rel;
   int exp_addr = 0;
   int rd_cnt = 0, en_cnt = 0, clr_cnt = 0;
   logic rst_d = 1'b0;
   logic [W-1:0] act_pkt, exp_pkt;
   logic [7:0]   act_b, exp_b;

   function automatic logic [W-1:0] pkt(input logic [1:0] kind, input logic addr,
                                        input int r, input logic [31:0] sum);
      return {kind, addr, 8'(r), sum};
   endfunction

   always @(negedge clk) begin
      ncyc++;
      rel = ncyc - base;
      if (rst_d) begin
         check("reset_outputs",
               {a_busy, a_done, a_rd_en, a_data_addr, a_wgt_grp, a_wgt_bank,
                a_acc_clr, a_acc_en, a_res_we, a_res_addr}, '0);
         check("reset_state", a_state, IDLE);
      end
      rst_d = rst;
      if (rst) begin
         exp_addr = 0;
         rd_cnt = 0;
         en_cnt = 0;
         clr_cnt = 0;
      end else begin
         if (a_rd_en) begin
            check("data_addr", a_data_addr, exp_addr);
            check("wgt_grp", a_wgt_grp, exp_addr);
            exp_addr = (exp_addr == NC - 1) ? 0 : exp_addr + 1;
            rd_cnt++;
         end
         if (a_busy)
            check("wgt_bank", a_wgt_bank, (rel <= NC + 2) ? 64'd0 : 64'd1);
         if (a_acc_en)
            en_cnt++;
         if (a_acc_clr) begin
            clr_cnt++;
            check("acc_clr_cycle", (rel == 1 || rel == NC + 3), 1);
         end
         if (a_res_we || a_done) begin
            act_pkt = a_done ? pkt(K_DONE, 1'b0, rel, 32'd0) : pkt(K_WR, a_res_addr[0], rel, acc);
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_event: got 0x%0h, expected none", act_pkt);
            end else begin
               exp_pkt = exp_q.pop_front();
               check("scoreboard", act_pkt, exp_pkt);
            end
         end
         if (a_done) begin
            check("rd_en_cycles", rd_cnt, NC * NB);
            check("acc_en_cycles", en_cnt, NC * NB);
            check("acc_clr_cycles", clr_cnt, NB);
            rd_cnt = 0;
            en_cnt = 0;
            clr_cnt = 0;
         end
      end
      if (!rst && (b_busy || b_done)) begin
         act_b = {b_busy, b_done, b_rd_en, b_acc_clr, b_acc_en, b_res_we, b_res_addr, b_data_addr};
         if (exp_b_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_b_cycle: got 0x%0h, expected none", act_b);
         end else begin
            exp_b = exp_b_q.pop_front();
            check("boundary_cycle", act_b, exp_b);
         end
      end
   end

   // driver tasks
   task automatic start_pass_a();
      @(posedge clk);
      #1 start_a = 1'b1;
      exp_q.push_back(pkt(K_WR, 1'b0, NC + 2, REF_SUM0));
      exp_q.push_back(pkt(K_WR, 1'b1, 2 * (NC + 2), REF_SUM1));
      exp_q.push_back(pkt(K_DONE, 1'b0, NB * (NC + 2) + 1, 32'd0));
      @(posedge clk);
      #1 start_a = 1'b0;
      base = ncyc;
   endtask

   task automatic wait_done_a(input int limit);
      int n = 0;
      while (!a_done && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (!a_done) begin
         tests++;
         fails++;
         $display("FAIL done_timeout: got no done, expected done within %0d cycles", limit);
      end
   endtask

   task automatic check_idle(input string name);
      repeat (2) @(negedge clk);
      check(name, {a_busy, a_state}, {1'b0, IDLE});
   endtask

   initial begin
      // reset held 3 cycles with start asserted
      start_a = 1'b1;
      start_b = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      repeat (2) @(negedge clk);
      check("no_run_after_reset_a", {a_busy, a_state}, {1'b0, IDLE});
      check("no_run_after_reset_b", {b_busy, b_state}, {1'b0, IDLE});

      // single full pass
      start_pass_a();
      wait_done_a(200);
      check_idle("idle_after_pass");

      // start pulses while busy are ignored
      start_pass_a();
      repeat (19) @(posedge clk);
      #1 start_a = 1'b1;
      @(posedge clk);
      #1 start_a = 1'b0;
      repeat (39) @(posedge clk);
      #1 start_a = 1'b1;
      @(posedge clk);
      #1 start_a = 1'b0;
      wait_done_a(200);
      check_idle("idle_after_ignored_start");

      // reset in cycle 30, then a clean replay
      start_pass_a();
      repeat (29) @(posedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      start_pass_a();
      wait_done_a(200);
      check_idle("idle_after_replay");

      // boundary: NUM_CHUNK=1, NUM_BATCH=1
      exp_b_q.push_back(8'b1011_0000);
      exp_b_q.push_back(8'b1000_1000);
      exp_b_q.push_back(8'b1000_0100);
      exp_b_q.push_back(8'b0100_0000);
      @(posedge clk);
      #1 start_b = 1'b1;
      @(posedge clk);
      #1 start_b = 1'b0;
      repeat (8) @(negedge clk);
      check("boundary_all_cycles_seen", exp_b_q.size(), 0);
      check("boundary_idle", {b_busy, b_state}, {1'b0, IDLE});
      check("scoreboard_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
